// File: rtl/serial_shifter.sv
// serial_shifter -- multi-cycle SLL/SRL/SRA unit for the MIPS datapath.
//
// Shifts one bit position per clock (or up to four when the optional
// fast-step mode is built in), then pulses done_o for one cycle with the
// result on data_o. data_o holds that result until the next done_o.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   start_i  request, sampled only while idle
//   op_i     00=SLL 01=SRL 10=SRA 11=pass-through
//   shamt_i  shift amount, captured with the request
//   data_i   operand, captured with the request
//   data_o   result (registered, updated on entry to DONE)
//   busy_o   high whenever not idle
//   done_o   one-cycle pulse, data_o valid in that cycle
//
// Optional feature (compile-time macro SERIAL_SHIFTER_STEP4_EN):
//   when defined, a counter value >= 4 shifts four positions per edge.
//   Results are identical to the one-bit mode; only latency changes.
module serial_shifter #(
  parameter int N_BITS     = 32,
  parameter int SHAMT_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [SHAMT_BITS-1:0] shamt_i,
  input  logic [N_BITS-1:0]     data_i,
  output logic [N_BITS-1:0]     data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  state_t                  state, state_nxt;
  logic [N_BITS-1:0]       sreg, sreg_nxt;
  logic [SHAMT_BITS-1:0]   cnt, cnt_nxt;
  logic [1:0]              op, op_nxt;
  logic [SHAMT_BITS-1:0]   step;
  logic [N_BITS-1:0]       shifted;

  // Positions moved on this SHIFT edge.
  always_comb begin
`ifdef SERIAL_SHIFTER_STEP4_EN
    step = (cnt >= SHAMT_BITS'(4)) ? SHAMT_BITS'(4) : SHAMT_BITS'(1);
`else
    step = SHAMT_BITS'(1);
`endif
  end

  // One shift step of the held operand; SRA refills with the sign bit.
  always_comb begin
    shifted = sreg;
    case (op)
      OP_SLL:  shifted = sreg << step;
      OP_SRL:  shifted = sreg >> step;
      OP_SRA:  shifted = $unsigned($signed(sreg) >>> step);
      default: shifted = sreg;
    endcase
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    op_nxt    = op;
    case (state)
      IDLE: begin
        if (start_i) begin
          sreg_nxt  = data_i;
          cnt_nxt   = shamt_i;
          op_nxt    = op_i;
          // Zero shift and pass-through finish straight from the accept edge.
          state_nxt = (shamt_i != '0 && op_i != OP_PASS) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        sreg_nxt = shifted;
        cnt_nxt  = cnt - step;
        if (cnt_nxt == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      op     <= '0;
      data_o <= '0;
      done_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      sreg   <= sreg_nxt;
      cnt    <= cnt_nxt;
      op     <= op_nxt;
      done_o <= (state_nxt == DONE);
      // Result register only moves on entry to DONE so it holds between ops.
      if (state_nxt == DONE) data_o <= sreg_nxt;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_serial_shifter.sv
module tb_serial_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [4:0]  shamt_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        busy_o;
  logic        done_o;

  int n_chk  = 0;
  int n_pass = 0;

  serial_shifter #(.N_BITS(32), .SHAMT_BITS(5)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
    .shamt_i(shamt_i), .data_i(data_i), .data_o(data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference: the architectural meaning of each op.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [4:0] sh,
                                             input logic [31:0] d);
    case (op)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b10:   return $unsigned($signed(d) >>> sh);
      default: return d;
    endcase
  endfunction

  // Edges from accept to done (inclusive of the accept edge).
  function automatic int ref_lat(input logic [1:0] op, input logic [4:0] sh);
    if (op == 2'b11) return 1;
`ifdef SERIAL_SHIFTER_STEP4_EN
    return int'(sh) / 4 + int'(sh) % 4 + 1;
`else
    return int'(sh) + 1;
`endif
  endfunction

  // Issue one request and follow it to completion. With junk set, start_i
  // stays asserted with fresh random operands throughout the busy period.
  task automatic run_op(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] d,
                        input bit junk, input string tag);
    logic [31:0] exp;
    int lat, idx;
    bit seen;
    exp = ref_result(op, sh, d);
    lat = ref_lat(op, sh);
    @(negedge clk);
    start_i = 1'b1; op_i = op; shamt_i = sh; data_i = d;
    @(posedge clk); #1;
    idx = 0; seen = 0;
    while (!seen && idx < 100) begin
      chk({tag, " busy"}, 32'(busy_o), 32'd1);
      if (done_o) begin
        seen = 1;
        chk({tag, " latency"}, 32'(idx), 32'(lat - 1));
        chk({tag, " data"}, data_o, exp);
      end
      start_i = junk; data_i = $urandom; op_i = 2'($urandom); shamt_i = 5'($urandom);
      if (!seen) begin
        @(posedge clk); #1;
        idx++;
      end
    end
    if (!seen) chk({tag, " done timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk({tag, " idle busy"}, 32'(busy_o), 32'd0);
    chk({tag, " idle done"}, 32'(done_o), 32'd0);
    chk({tag, " hold"}, data_o, exp);
    if (junk) begin
      // A start seen while busy must not have been queued.
      @(posedge clk); #1;
      chk({tag, " noqueue busy"}, 32'(busy_o), 32'd0);
      chk({tag, " noqueue done"}, 32'(done_o), 32'd0);
    end
  endtask

  initial begin
    #2;
    chk("reset data", data_o, 32'd0);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(2'b10, 5'd4,  32'h8000_0000, 0, "sra4");
    run_op(2'b00, 5'd31, 32'h0000_0001, 0, "sll31");
    run_op(2'b01, 5'd31, 32'h8000_0000, 0, "srl31");
    run_op(2'b01, 5'd8,  32'hFFFF_FFFF, 0, "srl8");
    run_op(2'b00, 5'd0,  32'h1234_5678, 0, "sll0");
    run_op(2'b11, 5'd7,  32'h1234_5678, 0, "pass");
    run_op(2'b10, 5'd31, 32'h8000_0001, 0, "sra31");
    run_op(2'b01, 5'd4,  32'hF000_0000, 1, "ignore");

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom), 5'($urandom), $urandom, bit'($urandom), $sformatf("rnd%0d", i));

    // Async reset in the middle of a long shift.
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b00; shamt_i = 5'd20; data_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst data", data_o, 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (i == 24) chk("rst no done", 32'(done_o), 32'd0);
      else if (done_o) chk("rst spurious done", 32'(done_o), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    run_op(2'b01, 5'd8, 32'h0000_0100, 0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
